// File: rtl/date_update_scheduler_pkg.sv
// Shared definitions for the date update scheduler.
//  - ui_state_t  : UI mode codes. The month/day counter decodes the same values.
//  - sch_state_t : grant-window phases.
//  - next_mode() : successor of a UI mode on a mode-button press.
package date_update_scheduler_pkg;

    typedef enum logic [3:0] {
        UI_RUN       = 4'd0,
        UI_TIME_SET  = 4'd5,
        UI_DATE_SET  = 4'd6,
        UI_ALARM_SET = 4'd7
    } ui_state_t;

    typedef enum logic [1:0] {
        SCH_IDLE,
        SCH_PULSE,
        SCH_SETTLE
    } sch_state_t;

    // Cycles cnt_state is held at DATE_SET for each granted event.
    localparam int WIN_LEN_DEFAULT = 3;

    // Largest number of day ticks that can wait for delivery.
    localparam logic [1:0] DAY_PEND_MAX = 2'd3;

    function automatic ui_state_t next_mode(input ui_state_t s);
        case (s)
            UI_RUN:      next_mode = UI_TIME_SET;
            UI_TIME_SET: next_mode = UI_DATE_SET;
            UI_DATE_SET: next_mode = UI_ALARM_SET;
            default:     next_mode = UI_RUN;
        endcase
    endfunction

endpackage

// File: rtl/date_update_scheduler_debounce.sv
// Button debouncer: 2-flop synchroniser, stability counter, rising-edge pulse.
//  clk    in  system clock
//  reset  in  asynchronous active-low reset
//  btn    in  raw button level, asynchronous to clk
//  press  out one-cycle pulse when the debounced level rises
// The debounced level follows the synchronised input only after DEB_CYC
// consecutive samples that disagree with it; any agreeing sample restarts
// the count, so shorter glitches are ignored.
module date_update_scheduler_debounce #(
    parameter int DEB_CYC = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DEB_CYC - 1)) begin
                level_reg <= sync2_reg;
                press_reg <= sync2_reg;   // only the rising transition is a press
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/date_update_scheduler.sv
// Schedules every access to the month/day counter.
//  clk        in   system clock
//  reset      in   asynchronous active-low reset
//  btn_mode   in   raw mode button
//  btn_up     in   raw month+1 button
//  btn_sel    in   raw day+1 button
//  day_tick   in   one-cycle midnight pulse from the time counter
//  ui_state   out  UI mode (RUN/TIME_SET/DATE_SET/ALARM_SET)
//  cnt_state  out  counter state input: DATE_SET inside a grant window, else ui_state
//  b1/b2      out  month / day increment pulses
//  b3         out  mode-press pulse
//  oneday     out  day-advance pulse
//  day_pend   out  undelivered day ticks, including one being delivered this cycle
//  busy       out  grant window active
// Each granted event opens a WIN_LEN-cycle window: one pulse cycle followed by
// settle cycles so the counter finishes any rollover before the next pulse.
module date_update_scheduler
    import date_update_scheduler_pkg::*;
#(
    parameter int DEB_CYC     = 250000,
    parameter int TIMEOUT_CYC = 500000000,
    parameter int WIN_LEN     = WIN_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_sel,
    input  logic       day_tick,
    output logic [3:0] ui_state,
    output logic [3:0] cnt_state,
    output logic       b1,
    output logic       b2,
    output logic       b3,
    output logic       oneday,
    output logic [1:0] day_pend,
    output logic       busy
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    // Debounced press events: [0]=mode, [1]=up, [2]=sel
    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {btn_sel, btn_up, btn_mode};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            date_update_scheduler_debounce #(
                .DEB_CYC (DEB_CYC)
            ) u_deb (
                .clk   (clk),
                .reset (reset),
                .btn   (btn_raw[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    // ---------------- mode FSM and idle timer ----------------
    ui_state_t     ui_state_reg;
    ui_state_t     ui_next;
    logic          b3_reg;
    logic [TW-1:0] idle_cnt_reg;
    logic          any_press;
    logic          timer_expire;

    assign any_press    = |press;
    // A press in the expiry cycle reloads the timer instead of expiring it.
    assign timer_expire = (ui_state_reg != UI_RUN) && !any_press &&
                          (idle_cnt_reg == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        ui_next = ui_state_reg;
        if (press[0]) begin
            ui_next = next_mode(ui_state_reg);
        end else if (timer_expire) begin
            ui_next = UI_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ui_state_reg <= UI_RUN;
            b3_reg       <= 1'b0;
            idle_cnt_reg <= '0;
        end else begin
            ui_state_reg <= ui_next;
            b3_reg       <= press[0];
            if (any_press || timer_expire || ui_state_reg == UI_RUN) begin
                idle_cnt_reg <= '0;
            end else begin
                idle_cnt_reg <= idle_cnt_reg + TW'(1);
            end
        end
    end

    // ---------------- event queues ----------------
    logic          up_pend_reg,  up_pend_next;
    logic          sel_pend_reg, sel_pend_next;
    logic [1:0]    day_pend_reg, day_pend_next;
    logic [1:0]    day_after;
    logic [WW-1:0] win_left_reg;
    logic          win_open;
    logic          grant_day, grant_up, grant_sel, grant_any;
    logic          oneday_reg, b1_reg, b2_reg;

    // The tick being pulsed this cycle leaves the queue at the end of the cycle,
    // so it must not be granted a second time.
    assign day_after = day_pend_reg - {1'b0, oneday_reg};
    assign win_open  = (win_left_reg == '0);
    assign grant_day = win_open && (day_after != 2'd0);
    assign grant_up  = win_open && !grant_day && up_pend_reg;
    assign grant_sel = win_open && !grant_day && !up_pend_reg && sel_pend_reg;
    assign grant_any = grant_day || grant_up || grant_sel;

    always_comb begin
        day_pend_next = day_after;
        if (day_tick && day_after != DAY_PEND_MAX) begin
            day_pend_next = day_after + 2'd1;
        end

        up_pend_next  = up_pend_reg;
        sel_pend_next = sel_pend_reg;
        if (grant_up)  up_pend_next  = 1'b0;
        if (grant_sel) sel_pend_next = 1'b0;
        if (press[1] && ui_state_reg == UI_DATE_SET && !up_pend_reg)  up_pend_next  = 1'b1;
        if (press[2] && ui_state_reg == UI_DATE_SET && !sel_pend_reg) sel_pend_next = 1'b1;
        // Button edits are meaningless once the user has left date-set mode.
        if (ui_next != UI_DATE_SET) begin
            up_pend_next  = 1'b0;
            sel_pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            day_pend_reg <= 2'd0;
            up_pend_reg  <= 1'b0;
            sel_pend_reg <= 1'b0;
        end else begin
            day_pend_reg <= day_pend_next;
            up_pend_reg  <= up_pend_next;
            sel_pend_reg <= sel_pend_next;
        end
    end

    // ---------------- scheduler FSM ----------------
    sch_state_t sch_state_reg;
    logic [3:0] cnt_state_reg;

    // The last window cycle may grant straight into the next window, giving
    // back-to-back pulses exactly WIN_LEN cycles apart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sch_state_reg <= SCH_IDLE;
            win_left_reg  <= '0;
            oneday_reg    <= 1'b0;
            b1_reg        <= 1'b0;
            b2_reg        <= 1'b0;
            cnt_state_reg <= UI_RUN;
        end else if (grant_any) begin
            sch_state_reg <= SCH_PULSE;
            win_left_reg  <= WW'(WIN_LEN - 1);
            oneday_reg    <= grant_day;
            b1_reg        <= grant_up;
            b2_reg        <= grant_sel;
            cnt_state_reg <= UI_DATE_SET;
        end else begin
            oneday_reg <= 1'b0;
            b1_reg     <= 1'b0;
            b2_reg     <= 1'b0;
            if (!win_open) begin
                sch_state_reg <= SCH_SETTLE;
                win_left_reg  <= win_left_reg - WW'(1);
                cnt_state_reg <= UI_DATE_SET;
            end else begin
                sch_state_reg <= SCH_IDLE;
                cnt_state_reg <= ui_next;
            end
        end
    end

    assign ui_state  = ui_state_reg;
    assign cnt_state = cnt_state_reg;
    assign b1        = b1_reg;
    assign b2        = b2_reg;
    assign b3        = b3_reg;
    assign oneday    = oneday_reg;
    assign day_pend  = day_pend_reg;
    assign busy      = (sch_state_reg != SCH_IDLE);

endmodule

// File: tb/tb_date_update_scheduler.sv
module tb_date_update_scheduler;
    localparam int DEB = 4;
    localparam int TMO = 100;
    localparam int WIN = 3;
    localparam int NR  = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_sel = 1'b0, day_tick = 1'b0;
    logic [3:0] ui_state, cnt_state;
    logic       b1, b2, b3, oneday, busy;
    logic [1:0] day_pend;

    always #5 clk = ~clk;

    date_update_scheduler #(
        .DEB_CYC     (DEB),
        .TIMEOUT_CYC (TMO),
        .WIN_LEN     (WIN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .btn_sel   (btn_sel),
        .day_tick  (day_tick),
        .ui_state  (ui_state),
        .cnt_state (cnt_state),
        .b1        (b1),
        .b2        (b2),
        .b3        (b3),
        .oneday    (oneday),
        .day_pend  (day_pend),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_b1, n_b2, n_b3, n_od;

    typedef struct {
        logic       tick;
        logic       od;
        logic       bz;
        logic [1:0] pend;
        logic [3:0] cs;
    } vec_t;
    vec_t tbl [9];

    // reference model state (random phase)
    bit raw_hist [3][NR];
    bit bval [3];
    int bhold [3];
    int m_mode, m_day, m_last_grant, m_last_press;
    bit m_up, m_sel, m_prev_od;

    function automatic logic [14:0] outs();
        return {ui_state, cnt_state, b1, b2, b3, oneday, day_pend, busy};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // advance to the next negedge and tally the pulses seen there
    task automatic step();
        @(negedge clk);
        n_b1 += int'(b1);
        n_b2 += int'(b2);
        n_b3 += int'(b3);
        n_od += int'(oneday);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        btn_mode = 1'b0; btn_up = 1'b0; btn_sel = 1'b0; day_tick = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_mode = v;
            1: btn_up   = v;
            default: btn_sel = v;
        endcase
    endtask

    task automatic press_btn(input int which, input int hold);
        set_btn(which, 1'b1);
        repeat (hold) step();
        set_btn(which, 1'b0);
        repeat (8) step();
    endtask

    function automatic int mode_code(input int idx);
        case (idx)
            0: return 0;
            1: return 5;
            2: return 6;
            default: return 7;
        endcase
    endfunction

    // A clean press is first sampled at edge f and acted on at edge f+2+DEB.
    function automatic bit model_press(input int b, input int n);
        int f;
        f = n - 2 - DEB;
        if (f < 0) return 1'b0;
        return raw_hist[b][f] && (f == 0 || !raw_hist[b][f-1]);
    endfunction

    task automatic model_step(input int n, input bit tick, output logic [14:0] exp);
        bit pm, pu, ps, any, in_date, g_day, g_up, g_sel, bz;
        int new_mode, cs;
        pm = model_press(0, n);
        pu = model_press(1, n);
        ps = model_press(2, n);
        any = pm || pu || ps;
        in_date = (mode_code(m_mode) == 6);
        new_mode = m_mode;
        if (pm) new_mode = (m_mode + 1) % 4;
        else if (m_mode != 0 && !any && n - m_last_press == TMO) new_mode = 0;
        if (any) m_last_press = n;
        // a pulse may start once the previous window of WIN cycles has ended
        g_day = (n - m_last_grant >= WIN) && (m_day - int'(m_prev_od) > 0);
        g_up  = (n - m_last_grant >= WIN) && !g_day && m_up;
        g_sel = (n - m_last_grant >= WIN) && !g_day && !g_up && m_sel;
        if (g_day || g_up || g_sel) m_last_grant = n;
        m_day = m_day - int'(m_prev_od);
        if (tick && m_day < 3) m_day++;
        if (pu && in_date && !m_up) m_up = 1'b1;
        else if (g_up) m_up = 1'b0;
        if (ps && in_date && !m_sel) m_sel = 1'b1;
        else if (g_sel) m_sel = 1'b0;
        if (mode_code(new_mode) != 6) begin
            m_up = 1'b0;
            m_sel = 1'b0;
        end
        m_mode = new_mode;
        m_prev_od = g_day;
        bz = (n - m_last_grant < WIN);
        cs = bz ? 6 : mode_code(m_mode);
        exp = {4'(mode_code(m_mode)), 4'(cs), g_up, g_sel, pm, g_day, 2'(m_day), bz};
    endtask

    initial begin
        int od_at, b1_at, bad_cs;
        logic [14:0] exp;

        // 1: reset in the middle of a grant window
        do_reset();
        day_tick = 1'b1; step(); day_tick = 1'b0; step();
        chk("t1_busy_before_reset", int'(busy), 1);
        #2 reset = 1'b0;
        #1 chk("t1_async_clear", int'(outs()), 0);
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t1_quiet_c%0d", i), int'(outs()), 0);
        end

        // 2: mode stepping and glitch rejection
        for (int i = 0; i < 3; i++) begin
            n_b3 = 0;
            press_btn(0, 8);
            chk($sformatf("t2_mode_%0d", i), int'(ui_state), mode_code(i + 1));
            chk($sformatf("t2_b3_%0d", i), n_b3, 1);
        end
        n_b3 = 0;
        press_btn(0, 3);
        chk("t2_glitch_mode", int'(ui_state), 7);
        chk("t2_glitch_b3", n_b3, 0);
        press_btn(0, 8);
        chk("t2_wrap_run", int'(ui_state), 0);

        // 3: two back-to-back day ticks in RUN
        do_reset();
        tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd1, 4'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 2'd2, 4'd6};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 2'd1, 4'd6};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 2'd1, 4'd6};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 2'd1, 4'd6};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 2'd0, 4'd6};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 2'd0, 4'd6};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 4'd0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 2'd0, 4'd0};
        for (int i = 0; i < 9; i++) begin
            day_tick = tbl[i].tick;
            step();
            chk($sformatf("t3_vec%0d", i), int'({oneday, busy, day_pend, cnt_state}),
                int'({tbl[i].od, tbl[i].bz, tbl[i].pend, tbl[i].cs}));
        end

        // 4: day tick and up press in the same cycle while in DATE_SET
        do_reset();
        press_btn(0, 8);
        press_btn(0, 8);
        chk("t4_in_date", int'(ui_state), 6);
        od_at = -1; b1_at = -1; bad_cs = 0; n_od = 0; n_b1 = 0;
        for (int k = 0; k < 26; k++) begin
            btn_up = (k < 8);
            day_tick = (k == 6);
            step();
            if (oneday && od_at < 0) od_at = k;
            if (b1 && b1_at < 0) b1_at = k;
            if (cnt_state != 4'd6) bad_cs++;
        end
        btn_up = 1'b0; day_tick = 1'b0;
        chk("t4_oneday_edge", od_at, 7);
        chk("t4_b1_gap", b1_at - od_at, 3);
        chk("t4_oneday_count", n_od, 1);
        chk("t4_b1_count", n_b1, 1);
        chk("t4_cnt_state_6", bad_cs, 0);

        // 5: five consecutive ticks saturate the queue
        do_reset();
        n_od = 0;
        for (int k = 0; k < 20; k++) begin
            day_tick = (k < 5);
            step();
            if (k == 4) begin
                chk("t5_saturated", int'(day_pend), 3);
                n_od = int'(oneday);
            end
        end
        day_tick = 1'b0;
        chk("t5_onedays_after_sat", n_od, 3);
        chk("t5_drained", int'(day_pend), 0);

        // 6: pending day press discarded on leaving DATE_SET, then idle timeout
        do_reset();
        press_btn(0, 8);
        press_btn(0, 8);
        n_b2 = 0; n_od = 0;
        for (int k = 0; k < 30; k++) begin
            btn_sel = (k < 8);
            btn_mode = (k >= 2 && k < 10);
            day_tick = (k >= 3 && k <= 5);
            step();
        end
        btn_sel = 1'b0; btn_mode = 1'b0; day_tick = 1'b0;
        chk("t6_b2_dropped", n_b2, 0);
        chk("t6_days_kept", n_od, 3);
        chk("t6_mode_alarm", int'(ui_state), 7);
        press_btn(0, 8);
        press_btn(0, 8);
        press_btn(0, 8);
        chk("t6_back_in_date", int'(ui_state), 6);
        repeat (60) step();
        chk("t6_before_timeout", int'(ui_state), 6);
        repeat (40) step();
        chk("t6_timeout_ui", int'(ui_state), 0);
        chk("t6_timeout_cnt", int'(cnt_state), 0);

        // random traffic against the reference model
        do_reset();
        m_mode = 0; m_day = 0; m_last_grant = -100; m_last_press = 0;
        m_up = 1'b0; m_sel = 1'b0; m_prev_od = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bval[b] = 1'b0;
            bhold[b] = 0;
        end
        for (int n = 0; n < NR; n++) begin
            for (int b = 0; b < 3; b++) begin
                if (bhold[b] > 0) bhold[b]--;
                else if (bval[b]) begin
                    bval[b] = 1'b0;
                    bhold[b] = $urandom_range(6, 12);
                end else if ($urandom_range(0, (b == 0) ? 39 : 11) == 0) begin
                    bval[b] = 1'b1;
                    bhold[b] = $urandom_range(5, 10);
                end
                raw_hist[b][n] = bval[b];
            end
            btn_mode = bval[0];
            btn_up   = bval[1];
            btn_sel  = bval[2];
            day_tick = ($urandom_range(0, 5) == 0);
            step();
            model_step(n, day_tick, exp);
            chk($sformatf("rand_c%0d", n), int'(outs()), int'(exp));
        end
        btn_mode = 1'b0; btn_up = 1'b0; btn_sel = 1'b0; day_tick = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
